// File: rtl/clk_div_detector.sv
// Recovers the divide select (/2../16) of a clk-synchronous divided clock by
// measuring its period and duty cycle, with lock tracking and violation pulses.
`timescale 1ns/1ps
module clk_div_detector #(
    parameter int LOCK_COUNT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_in,
    output logic [1:0] sel_det,
    output logic       locked,
    output logic       err,
    output logic [4:0] period,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2} state_t;

    localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

    state_t     state, state_next;
    logic       clk_in_q;
    logic [4:0] cnt;
    logic [4:0] hi;
    logic [1:0] cand, cand_next;
    logic [3:0] match_cnt, match_next;
    logic [1:0] sel_next;
    logic       locked_next;
    logic       err_next;
    logic [4:0] period_next;

    logic       edge_det;
    logic [4:0] meas;
    logic       meas_pow2;
    logic [1:0] meas_sel;
    logic       meas_valid;
    logic       timeout;
    logic [3:0] match_inc;
    logic       lock_hit;
    logic       locked_ok;

    assign edge_det = clk_in & ~clk_in_q;
    assign meas     = (cnt == 5'd31) ? 5'd31 : cnt + 5'd1;

    always_comb begin
        meas_pow2 = 1'b1;
        meas_sel  = 2'd0;
        case (meas)
            5'd2:    meas_sel = 2'd0;
            5'd4:    meas_sel = 2'd1;
            5'd8:    meas_sel = 2'd2;
            5'd16:   meas_sel = 2'd3;
            default: meas_pow2 = 1'b0;
        endcase
    end

    // A period only counts when its high phase is exactly half of it.
    assign meas_valid = meas_pow2 && (hi == {1'b0, meas[4:1]});
    // An edge in the cycle cnt would saturate wins over the timeout.
    assign timeout    = !edge_det && (cnt == 5'd30) && (state != IDLE);
    assign match_inc  = (meas_sel == cand) ? match_cnt + 4'd1 : 4'd1;
    assign lock_hit   = meas_valid && (match_inc == LOCK_N);
    assign locked_ok  = meas_valid && (meas_sel == cand);
    assign dbg_state  = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (edge_det) state_next = ACQUIRE;
            ACQUIRE: begin
                if (timeout)                  state_next = IDLE;
                else if (edge_det && lock_hit) state_next = LOCKED;
            end
            LOCKED: begin
                if (timeout)                    state_next = IDLE;
                else if (edge_det && !locked_ok) state_next = ACQUIRE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cand_next   = cand;
        match_next  = match_cnt;
        sel_next    = sel_det;
        locked_next = locked;
        err_next    = 1'b0;
        period_next = period;
        if (timeout) begin
            err_next    = 1'b1;
            locked_next = 1'b0;
            match_next  = 4'd0;
        end else if (edge_det && state != IDLE) begin
            period_next = meas;
            if (state == ACQUIRE) begin
                if (!meas_valid) begin
                    match_next = 4'd0;
                    err_next   = 1'b1;
                end else begin
                    cand_next  = meas_sel;
                    match_next = match_inc;
                    if (lock_hit) begin
                        sel_next    = meas_sel;
                        locked_next = 1'b1;
                    end
                end
            end else if (!locked_ok) begin
                err_next    = 1'b1;
                locked_next = 1'b0;
                cand_next   = meas_valid ? meas_sel : cand;
                match_next  = meas_valid ? 4'd1 : 4'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_in_q  <= 1'b0;
            cnt       <= 5'd0;
            hi        <= 5'd0;
            cand      <= 2'd0;
            match_cnt <= 4'd0;
            sel_det   <= 2'd0;
            locked    <= 1'b0;
            err       <= 1'b0;
            period    <= 5'd0;
        end else begin
            clk_in_q  <= clk_in;
            if (edge_det)          cnt <= 5'd0;
            else if (cnt != 5'd31) cnt <= cnt + 5'd1;
            if (edge_det)                   hi <= 5'd1;
            else if (clk_in && hi != 5'd31) hi <= hi + 5'd1;
            cand      <= cand_next;
            match_cnt <= match_next;
            sel_det   <= sel_next;
            locked    <= locked_next;
            err       <= err_next;
            period    <= period_next;
        end
    end

endmodule

// File: tb/tb_clk_div_detector.sv
// Directed bench for clk_div_detector: per-period stimulus with hand-computed
// expectations queued at each rising edge of clk_in.
`timescale 1ns/1ps
module tb_clk_div_detector;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_in;
  logic [1:0] sel_det;
  logic       locked;
  logic       err;
  logic [4:0] period;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [8:0] exp_q[$];
  logic       edge_pending = 1'b0;
  logic       prev_in = 1'b0;

  // clock / reset
  always #5 clk = ~clk;

  clk_div_detector #(.LOCK_COUNT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_in    (clk_in),
    .sel_det   (sel_det),
    .locked    (locked),
    .err       (err),
    .period    (period),
    .dbg_state (dbg_state)
  );

  function automatic logic [8:0] pack_exp(input logic e, input logic l,
                                          input logic [1:0] s, input logic [4:0] p);
    return {e, l, s, p};
  endfunction

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h (err,locked,sel,period)", tag, obs, exp);
  endtask

  // driver: one clk cycle of clk_in, scoreboard compare on the cycle after an edge
  task automatic step(input logic v);
    logic [8:0] e;
    @(negedge clk);
    if (edge_pending) begin
      if (exp_q.size() == 0) begin
        check("edge_no_expect", pack_exp(err, locked, sel_det, period), 9'h1ff);
      end else begin
        e = exp_q.pop_front();
        check("edge", pack_exp(err, locked, sel_det, period), e);
      end
    end else begin
      check("err_quiet", {8'd0, err}, 9'd0);
    end
    clk_in = v;
    edge_pending = v & ~prev_in;
    prev_in = v;
  endtask

  // one clk_in period: expectation applies to the rising edge that opens it
  task automatic send(input int h, input int l, input logic e, input logic lk,
                      input logic [1:0] s, input logic [4:0] p);
    exp_q.push_back(pack_exp(e, lk, s, p));
    for (int i = 0; i < h + l; i++) step(i < h);
  endtask

  task automatic idle_cycles(input int n, input int exp_pulses);
    int pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (err) pulses++;
      clk_in = 1'b0;
      prev_in = 1'b0;
      edge_pending = 1'b0;
    end
    check("err_pulses", 9'(pulses), 9'(exp_pulses));
  endtask

  initial begin
    rst = 1'b0;
    clk_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", pack_exp(err, locked, sel_det, period), 9'd0);
    check("reset_state", {7'd0, dbg_state}, 9'd0);
    rst = 1'b1;
    idle_cycles(5, 0);

    // lock at /4
    send(2, 2, 0, 0, 0, 0);
    send(2, 2, 0, 0, 0, 4);
    send(2, 2, 0, 0, 0, 4);
    send(2, 2, 0, 0, 0, 4);
    send(2, 2, 0, 1, 1, 4);
    send(2, 2, 0, 1, 1, 4);

    // /2
    send(1, 1, 0, 1, 1, 4);
    send(1, 1, 1, 0, 1, 2);
    send(1, 1, 0, 0, 1, 2);
    send(1, 1, 0, 0, 1, 2);
    send(1, 1, 0, 1, 0, 2);
    send(1, 1, 0, 1, 0, 2);

    // /16
    send(8, 8, 0, 1, 0, 2);
    send(8, 8, 1, 0, 0, 16);
    send(8, 8, 0, 0, 0, 16);
    send(8, 8, 0, 0, 0, 16);
    send(8, 8, 0, 1, 3, 16);

    // /8
    send(4, 4, 0, 1, 3, 16);
    send(4, 4, 1, 0, 3, 8);
    send(4, 4, 0, 0, 3, 8);
    send(4, 4, 0, 0, 3, 8);
    send(4, 4, 0, 1, 2, 8);

    // stuck clock while locked at /8: one timeout pulse, select held
    idle_cycles(45, 1);
    check("stuck_locked", {8'd0, locked}, 9'd0);
    check("stuck_sel", {7'd0, sel_det}, 9'd2);
    check("stuck_period", {4'd0, period}, 9'd8);
    check("stuck_state", {7'd0, dbg_state}, 9'd0);
    idle_cycles(20, 0);

    // reacquire /8
    send(4, 4, 0, 0, 2, 8);
    send(4, 4, 0, 0, 2, 8);
    send(4, 4, 0, 0, 2, 8);
    send(4, 4, 0, 0, 2, 8);
    send(4, 4, 0, 1, 2, 8);

    // switch /8 -> /4 while locked
    send(2, 2, 0, 1, 2, 8);
    send(2, 2, 1, 0, 2, 4);
    send(2, 2, 0, 0, 2, 4);
    send(2, 2, 0, 0, 2, 4);
    send(2, 2, 0, 1, 1, 4);

    // period 6, period 4 with high 1, period 31 (edge coincides with timeout point)
    send(3, 3, 0, 1, 1, 4);
    send(1, 3, 1, 0, 1, 6);
    send(15, 16, 1, 0, 1, 4);
    send(2, 2, 1, 0, 1, 31);
    send(2, 2, 0, 0, 1, 4);
    send(2, 2, 0, 0, 1, 4);

    // async reset mid-acquire, between clk edges
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_outputs", pack_exp(err, locked, sel_det, period), 9'd0);
    check("async_rst_state", {7'd0, dbg_state}, 9'd0);
    repeat (3) begin
      @(negedge clk);
      check("rst_hold", pack_exp(err, locked, sel_det, period), 9'd0);
    end
    rst = 1'b1;
    prev_in = 1'b0;
    edge_pending = 1'b0;
    idle_cycles(4, 0);

    // reacquire /4 after reset
    send(2, 2, 0, 0, 0, 0);
    send(2, 2, 0, 0, 0, 4);
    send(2, 2, 0, 0, 0, 4);
    send(2, 2, 0, 0, 0, 4);
    send(2, 2, 0, 1, 1, 4);
    send(2, 2, 0, 1, 1, 4);

    check("queue_empty", 9'(exp_q.size()), 9'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
